// File: rtl/fdiv_seq_ctrl_pkg.sv
// Shared types and defaults for the FP divide/sqrt sequencer.
// State encoding is fixed because the pipeline debug view decodes it.
package fdiv_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   localparam int DIV_CYCLES  = 24;
   localparam int SQRT_CYCLES = 26;
   localparam int CW          = 5;

   // Value loaded into the countdown when an op is accepted.
   function automatic logic [CW-1:0] first_count(input logic is_sqrt, input int div_n, input int sqrt_n);
      return is_sqrt ? CW'(sqrt_n - 1) : CW'(div_n - 1);
   endfunction

endpackage

// File: rtl/fdiv_seq_ctrl_if.sv
// ID-stage / writeback handshake between the FPU pipeline and the divide sequencer.
// master = pipeline side driving issue and ack, slave = sequencer.
interface fdiv_seq_ctrl_if #(
   parameter int CW = fdiv_ctrl_pkg::CW
);
   logic          start_div;
   logic          start_sqrt;
   logic [4:0]    fd;
   logic [4:0]    fs;
   logic [4:0]    ft;
   logic          use_fs;
   logic          use_ft;
   logic          wb_ack;
   logic          cancel;

   logic          load;
   logic          iter;
   logic          op_sqrt;
   logic [CW-1:0] count;
   logic          busy;
   logic          stall;
   logic          e;
   logic          wb_valid;
   logic [4:0]    wb_rd;

   modport master (
      output start_div, start_sqrt, fd, fs, ft, use_fs, use_ft, wb_ack, cancel,
      input  load, iter, op_sqrt, count, busy, stall, e, wb_valid, wb_rd
   );

   modport slave (
      input  start_div, start_sqrt, fd, fs, ft, use_fs, use_ft, wb_ack, cancel,
      output load, iter, op_sqrt, count, busy, stall, e, wb_valid, wb_rd
   );
endinterface

// File: rtl/fdiv_seq_ctrl_dffe5.sv
// 5-bit enabled register with async active-low clear; holds the destination fd.
module dffe5 (
   input  logic       clk,
   input  logic       clrn,
   input  logic       e,
   input  logic [4:0] d,
   output logic [4:0] q
);
   logic [4:0] data_q;
   logic [4:0] data_d;

   always_comb begin
      data_d = e ? d : data_q;
   end

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         data_q <= '0;
      end else begin
         data_q <= data_d;
      end
   end

   assign q = data_q;
endmodule

// File: rtl/fdiv_seq_ctrl.sv
// Divide/sqrt sequencer: accepted start -> wb_valid after N+1 cycles, held until wb_ack; stalls ID on busy unit or RAW on held fd.
// Optional FDIV_CANCEL_EN lets cancel abort an in-flight op; otherwise cancel is ignored.
module fdiv_seq_ctrl
   import fdiv_ctrl_pkg::*;
#(
   parameter int DIV_CYCLES  = fdiv_ctrl_pkg::DIV_CYCLES,
   parameter int SQRT_CYCLES = fdiv_ctrl_pkg::SQRT_CYCLES,
   parameter int CW          = fdiv_ctrl_pkg::CW
) (
   input  logic             clk,
   input  logic             clrn,
   fdiv_seq_ctrl_if.slave   ctl
);

   state_e        state_q, state_d;
   logic [CW-1:0] count_q, count_d;
   logic          op_sqrt_q, op_sqrt_d;
   logic          iter_q, iter_d;
   logic          busy_q, busy_d;
   logic          wb_valid_q, wb_valid_d;

   logic          start;
   logic          raw_hit;
   logic          struct_stall;
   logic          stall;
   logic          accept;
   logic          kill;
   logic [4:0]    wb_rd;

`ifdef FDIV_CANCEL_EN
   assign kill = ctl.cancel & (state_q != ST_IDLE);
`else
   logic unused_cancel;
   assign unused_cancel = ctl.cancel;
   assign kill          = 1'b0;
`endif

   always_comb begin
      start        = ctl.start_div | ctl.start_sqrt;
      // No bypass from the divider: any reader of the held fd waits until writeback has retired.
      raw_hit      = busy_q & ((ctl.use_fs & (ctl.fs == wb_rd)) | (ctl.use_ft & (ctl.ft == wb_rd)));
      struct_stall = start & ((state_q == ST_RUN) | ((state_q == ST_DONE) & ~ctl.wb_ack));
      stall        = raw_hit | struct_stall;
      accept       = start & ~stall & ~kill &
                     ((state_q == ST_IDLE) | ((state_q == ST_DONE) & ctl.wb_ack));
   end

   always_comb begin
      state_d   = state_q;
      count_d   = count_q;
      op_sqrt_d = op_sqrt_q;
      if (kill) begin
         state_d = ST_IDLE;
         count_d = '0;
      end else if (accept) begin
         state_d   = ST_RUN;
         count_d   = first_count(ctl.start_sqrt, DIV_CYCLES, SQRT_CYCLES);
         op_sqrt_d = ctl.start_sqrt;
      end else begin
         case (state_q)
            ST_IDLE: ;
            ST_RUN: begin
               if (count_q == '0) begin
                  state_d = ST_DONE;
               end else begin
                  count_d = count_q - 1'b1;
               end
            end
            ST_DONE: begin
               if (ctl.wb_ack) begin
                  state_d = ST_IDLE;
               end
            end
            default: begin
               state_d = ST_IDLE;
               count_d = '0;
            end
         endcase
      end
      iter_d     = (state_d == ST_RUN);
      busy_d     = (state_d != ST_IDLE);
      wb_valid_d = (state_d == ST_DONE);
   end

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         state_q    <= ST_IDLE;
         count_q    <= '0;
         op_sqrt_q  <= 1'b0;
         iter_q     <= 1'b0;
         busy_q     <= 1'b0;
         wb_valid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         count_q    <= count_d;
         op_sqrt_q  <= op_sqrt_d;
         iter_q     <= iter_d;
         busy_q     <= busy_d;
         wb_valid_q <= wb_valid_d;
      end
   end

   dffe5 u_wb_rd (
      .clk  (clk),
      .clrn (clrn),
      .e    (accept),
      .d    (ctl.fd),
      .q    (wb_rd)
   );

   assign ctl.load     = accept;
   assign ctl.iter     = iter_q;
   assign ctl.op_sqrt  = op_sqrt_q;
   assign ctl.count    = count_q;
   assign ctl.busy     = busy_q;
   assign ctl.stall    = stall;
   assign ctl.e        = ~stall;
   assign ctl.wb_valid = wb_valid_q;
   assign ctl.wb_rd    = wb_rd;

   a_one_start : assert property (@(posedge clk) disable iff (!clrn)
      !(ctl.start_div && ctl.start_sqrt));

endmodule

// File: tb/tb_fdiv_seq_ctrl.sv
// Directed bench for fdiv_seq_ctrl: reset, div/sqrt latency, structural and RAW stalls, DONE hold, cancel.
module tb_fdiv_seq_ctrl;

   logic clk = 1'b0;
   logic clrn;
   always #5 clk = ~clk;

   fdiv_seq_ctrl_if #(.CW(5)) bus ();

   fdiv_seq_ctrl dut (
      .clk  (clk),
      .clrn (clrn),
      .ctl  (bus)
   );

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Leaves us 2 ns after the n-th rising edge, well clear of the edge.
   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic idle_inputs();
      bus.start_div  = 1'b0;
      bus.start_sqrt = 1'b0;
      bus.fd         = 5'd0;
      bus.fs         = 5'd0;
      bus.ft         = 5'd0;
      bus.use_fs     = 1'b0;
      bus.use_ft     = 1'b0;
      bus.wb_ack     = 1'b0;
      bus.cancel     = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1);
   end

   initial begin
      clrn = 1'b0;
      idle_inputs();
      #3;
      chk("rst_busy",     bus.busy,     0);
      chk("rst_wb_valid", bus.wb_valid, 0);
      chk("rst_count",    bus.count,    0);
      chk("rst_op_sqrt",  bus.op_sqrt,  0);
      chk("rst_wb_rd",    bus.wb_rd,    0);
      chk("rst_load",     bus.load,     0);
      chk("rst_iter",     bus.iter,     0);
      chk("rst_stall",    bus.stall,    0);
      chk("rst_e",        bus.e,        1);
      cyc(2);
      clrn = 1'b1;
      cyc(1);

      // fdiv fd=9: load in the issue cycle t0, wb_valid at t0+25
      bus.start_div = 1'b1; bus.fd = 5'd9; #1;
      chk("div_load",  bus.load,  1);
      chk("div_stall", bus.stall, 0);
      cyc(1); bus.start_div = 1'b0; bus.fd = 5'd0; #1;
      chk("div_t1_count",   bus.count,   23);
      chk("div_t1_busy",    bus.busy,    1);
      chk("div_t1_iter",    bus.iter,    1);
      chk("div_t1_wb_rd",   bus.wb_rd,   9);
      chk("div_t1_op_sqrt", bus.op_sqrt, 0);
      chk("div_t1_load",    bus.load,    0);
      cyc(23);
      chk("div_t24_count", bus.count,    0);
      chk("div_t24_wbv",   bus.wb_valid, 0);
      chk("div_t24_iter",  bus.iter,     1);
      cyc(1);
      chk("div_t25_wbv",   bus.wb_valid, 1);
      chk("div_t25_wb_rd", bus.wb_rd,    9);
      chk("div_t25_iter",  bus.iter,     0);
      cyc(1);
      chk("div_t26_wbv", bus.wb_valid, 1);
      cyc(1); bus.wb_ack = 1'b1; #1;
      chk("div_t27_wbv", bus.wb_valid, 1);
      cyc(1); bus.wb_ack = 1'b0; #1;
      chk("div_t28_busy", bus.busy,     0);
      chk("div_t28_wbv",  bus.wb_valid, 0);

      // RAW on held fd=3, wb_ack ignored in RUN, DONE hold for 10 cycles
      bus.start_div = 1'b1; bus.fd = 5'd3;
      cyc(1); bus.start_div = 1'b0; bus.fd = 5'd0;
      bus.fs = 5'd3; bus.use_fs = 1'b1; #1;
      chk("raw_fs_stall", bus.stall, 1);
      chk("raw_fs_e",     bus.e,     0);
      bus.use_fs = 1'b0; bus.ft = 5'd3; bus.use_ft = 1'b0; #1;
      chk("raw_ft_unused_stall", bus.stall, 0);
      chk("raw_ft_unused_e",     bus.e,     1);
      bus.use_ft = 1'b1; #1;
      chk("raw_ft_stall", bus.stall, 1);
      bus.use_ft = 1'b0; bus.fs = 5'd4; bus.use_fs = 1'b1; #1;
      chk("raw_nomatch_stall", bus.stall, 0);
      bus.wb_ack = 1'b1;
      cyc(1); bus.wb_ack = 1'b0; #1;
      chk("run_ack_busy",  bus.busy,  1);
      chk("run_ack_count", bus.count, 22);
      bus.fs = 5'd3;
      cyc(23);
      for (int i = 0; i < 10; i++) begin
         chk("hold_wbv",   bus.wb_valid, 1);
         chk("hold_wb_rd", bus.wb_rd,    3);
         chk("hold_count", bus.count,    0);
         chk("hold_stall", bus.stall,    1);
         cyc(1);
      end
      bus.wb_ack = 1'b1; #1;
      chk("raw_ack_stall", bus.stall,    1);
      chk("raw_ack_wbv",   bus.wb_valid, 1);
      cyc(1); bus.wb_ack = 1'b0; #1;
      chk("raw_after_busy",  bus.busy,  0);
      chk("raw_after_stall", bus.stall, 0);
      bus.use_fs = 1'b0; bus.fs = 5'd0;

      // fsqrt issued during fdiv RUN waits, then starts on the ack edge
      bus.start_div = 1'b1; bus.fd = 5'd7;
      cyc(1); bus.start_div = 1'b0;
      bus.start_sqrt = 1'b1; bus.fd = 5'd12; #1;
      chk("b2b_run_stall", bus.stall, 1);
      chk("b2b_run_e",     bus.e,     0);
      chk("b2b_run_load",  bus.load,  0);
      cyc(23);
      chk("b2b_last_stall", bus.stall, 1);
      cyc(1);
      chk("b2b_done_wbv",   bus.wb_valid, 1);
      chk("b2b_done_stall", bus.stall,    1);
      chk("b2b_done_wb_rd", bus.wb_rd,    7);
      cyc(1); bus.wb_ack = 1'b1; #1;
      chk("b2b_ack_stall", bus.stall, 0);
      chk("b2b_ack_e",     bus.e,     1);
      chk("b2b_ack_load",  bus.load,  1);
      cyc(1); bus.wb_ack = 1'b0; bus.start_sqrt = 1'b0; bus.fd = 5'd0; #1;
      chk("sqrt_s1_op_sqrt", bus.op_sqrt,  1);
      chk("sqrt_s1_count",   bus.count,    25);
      chk("sqrt_s1_wb_rd",   bus.wb_rd,    12);
      chk("sqrt_s1_busy",    bus.busy,     1);
      chk("sqrt_s1_wbv",     bus.wb_valid, 0);
      chk("sqrt_s1_iter",    bus.iter,     1);
      cyc(25);
      chk("sqrt_s26_count", bus.count,    0);
      chk("sqrt_s26_wbv",   bus.wb_valid, 0);
      cyc(1);
      chk("sqrt_s27_wbv",   bus.wb_valid, 1);
      chk("sqrt_s27_wb_rd", bus.wb_rd,    12);
      bus.wb_ack = 1'b1;
      cyc(1); bus.wb_ack = 1'b0; #1;
      chk("sqrt_idle_busy", bus.busy, 0);

      // Asynchronous reset in the middle of RUN
      bus.start_div = 1'b1; bus.fd = 5'd5;
      cyc(1); bus.start_div = 1'b0; bus.fd = 5'd0;
      cyc(16);
      chk("mid_count", bus.count, 7);
      clrn = 1'b0; #1;
      chk("arst_busy",  bus.busy,     0);
      chk("arst_wbv",   bus.wb_valid, 0);
      chk("arst_e",     bus.e,        1);
      chk("arst_count", bus.count,    0);
      chk("arst_iter",  bus.iter,     0);
      cyc(1); clrn = 1'b1;
      cyc(1);

      // cancel at count=12
      bus.start_div = 1'b1; bus.fd = 5'd6;
      cyc(1); bus.start_div = 1'b0; bus.fd = 5'd0;
      cyc(11);
      chk("cancel_pre_count", bus.count, 12);
      bus.cancel = 1'b1;
      cyc(1); bus.cancel = 1'b0; #1;
`ifdef FDIV_CANCEL_EN
      chk("cancel_busy",  bus.busy,     0);
      chk("cancel_count", bus.count,    0);
      chk("cancel_wbv",   bus.wb_valid, 0);
      for (int i = 0; i < 20; i++) begin
         cyc(1);
         chk("cancel_no_wbv", bus.wb_valid, 0);
      end
`else
      chk("nocancel_busy",  bus.busy,  1);
      chk("nocancel_count", bus.count, 11);
      cyc(12);
      chk("nocancel_wbv",   bus.wb_valid, 1);
      chk("nocancel_wb_rd", bus.wb_rd,    6);
      bus.wb_ack = 1'b1;
      cyc(1); bus.wb_ack = 1'b0; #1;
      chk("nocancel_idle", bus.busy, 0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
